// File: rtl/cpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_pkg
//   Shared definitions for the simple_cpu instruction sequencer: instruction
//   class encodings (taken from instruction[19:18]), sequencer states, the
//   default hold-cycle constants and the hold-count decode helper.
// ---------------------------------------------------------------------------
package cpu_seq_pkg;

  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int DEF_ALU_CYCLES   = 3;
  localparam int DEF_STORE_CYCLES = 3;
  localparam int DEF_LOAD_CYCLES  = 4;

  // The hold counter is 4 bits wide, so legal hold counts are 1..15.
  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seq_state_t;

  // Returns N-1 for the class: the counter is loaded with this value on the
  // issuing edge and the instruction ends on the edge that sees it at zero.
  function automatic logic [CNT_BITS-1:0] hold_last(input logic [1:0] cls,
                                                    input int alu_n,
                                                    input int store_n,
                                                    input int load_n);
    int n;
    case (cls)
      CLS_LOAD:  n = load_n;
      CLS_STORE: n = store_n;
      default:   n = alu_n;
    endcase
    return CNT_BITS'(n - 1);
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// ---------------------------------------------------------------------------
// seq_prog_mem
//   Program memory for the sequencer: 2^PC_BITS words of INSTR_WIDTH bits.
//   Synchronous write, asynchronous read. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write strobe (already qualified by the sequencer)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
// ---------------------------------------------------------------------------
module seq_prog_mem #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [PC_BITS-1:0]     raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_instr_sequencer
//   Issues program words to simple_cpu one at a time, holding each stable for
//   the number of cycles its class needs (ALU / STORE_R / LOAD_R). Supports a
//   full run (start), single step (step) and a graceful halt (halt_req).
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   prog_we/addr/data - program memory write, honoured only in IDLE
//   last_pc         - address of the final program instruction
//   start, step     - single-cycle requests, accepted only in IDLE
//   halt_req        - stop after the current instruction (RUN only)
//   instruction     - registered word to the CPU (0 when idle)
//   instr_valid     - instruction carries a program word
//   pc              - address of issued word, or next word when idle
//   busy            - high in RUN or STEP
//   done            - one-cycle pulse when a run completes last_pc
//   retired         - (CPU_SEQ_RETIRE_COUNT_EN only) completed instructions
//   state           - FSM state, for observation
//
// Request protocol: start/step are one-cycle pulses sampled on the rising
// edge; they are accepted only when busy is low and prog_we is low in that
// same cycle (prog_we > start > step). Acceptance is visible as busy=1 and
// instr_valid=1 after the sampling edge; there is no acknowledge and dropped
// requests are not remembered.
//
// Optional feature macro: CPU_SEQ_RETIRE_COUNT_EN adds the retired counter.
// ---------------------------------------------------------------------------
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_WIDTH  = 20,
  parameter int PC_BITS      = 5,
  parameter int ALU_CYCLES   = DEF_ALU_CYCLES,
  parameter int STORE_CYCLES = DEF_STORE_CYCLES,
  parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic [PC_BITS-1:0]     last_pc,
  input  logic                   start,
  input  logic                   step,
  input  logic                   halt_req,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
`ifdef CPU_SEQ_RETIRE_COUNT_EN
  output logic [15:0]            retired,
`endif
  output seq_state_t             state
);

  logic [CNT_BITS-1:0]    cnt;
  logic                   halt_seen;
  logic                   mem_we;
  logic [PC_BITS-1:0]     rd_addr;
  logic [PC_BITS-1:0]     pc_next;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [CNT_BITS-1:0]    rd_hold;
  logic                   halt_now;
  logic                   hold_end;

  // Natural wrap modulo 2^PC_BITS.
  assign pc_next = pc + 1'b1;

  // One read port serves all issue cases: mem[0] on start, mem[pc] on step,
  // and mem[pc+1] for back-to-back issue while running.
  always_comb begin
    rd_addr = pc_next;
    if (state == IDLE) begin
      rd_addr = start ? '0 : pc;
    end
  end

  assign mem_we   = prog_we && (state == IDLE);
  assign rd_hold  = hold_last(rd_data[INSTR_WIDTH-1 -: 2],
                              ALU_CYCLES, STORE_CYCLES, LOAD_CYCLES);
  // A halt arriving on the final hold edge still counts for this instruction.
  assign halt_now = halt_seen | halt_req;
  assign hold_end = (state != IDLE) && (cnt == '0);

  seq_prog_mem #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .PC_BITS    (PC_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      halt_seen   <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          halt_seen <= 1'b0;
          // A write occupies the cycle; a simultaneous start/step is dropped.
          if (!prog_we && start) begin
            state       <= RUN;
            busy        <= 1'b1;
            pc          <= '0;
            instruction <= rd_data;
            instr_valid <= 1'b1;
            cnt         <= rd_hold;
          end else if (!prog_we && step) begin
            state       <= STEP;
            busy        <= 1'b1;
            instruction <= rd_data;
            instr_valid <= 1'b1;
            cnt         <= rd_hold;
          end
        end

        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (halt_req) begin
              halt_seen <= 1'b1;
            end
          end else if (pc == last_pc || halt_now) begin
            state       <= IDLE;
            busy        <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            halt_seen   <= 1'b0;
            if (pc == last_pc) begin
              done <= 1'b1;
              pc   <= '0;
            end else begin
              pc <= pc_next;
            end
          end else begin
            // Back-to-back issue: next word lands on the edge ending this one.
            pc          <= pc_next;
            instruction <= rd_data;
            cnt         <= rd_hold;
            halt_seen   <= 1'b0;
          end
        end

        STEP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= IDLE;
            busy        <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            halt_seen   <= 1'b0;
            pc          <= (pc == last_pc) ? '0 : pc_next;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          busy        <= 1'b0;
          instruction <= '0;
          instr_valid <= 1'b0;
          halt_seen   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_SEQ_RETIRE_COUNT_EN
  // Counts hold completions in RUN or STEP; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (state == IDLE && !prog_we && start) begin
      retired <= '0;
    end else if (hold_end) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_instr_sequencer
//   Directed stimulus with a scoreboard: every expected (pc, instruction)
//   cycle is queued when stimulus is issued, and a monitor pops one entry per
//   cycle in which instr_valid is high.
// ---------------------------------------------------------------------------
module tb_cpu_instr_sequencer;
  import cpu_seq_pkg::*;

  localparam int IW = 20;
  localparam int PB = 5;
  localparam int EW = IW + PB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          prog_we = 1'b0;
  logic [PB-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [PB-1:0] last_pc = '0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          halt_req = 1'b0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          busy;
  logic          done;
  seq_state_t    state;
`ifdef CPU_SEQ_RETIRE_COUNT_EN
  logic [15:0]   retired;
`endif

  cpu_instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .last_pc    (last_pc),
    .start      (start),
    .step       (step),
    .halt_req   (halt_req),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
`ifdef CPU_SEQ_RETIRE_COUNT_EN
    .retired    (retired),
`endif
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [IW-1:0] words [7] = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0,
                               20'hCC160, 20'hB80F0, 20'h8C160};

  function automatic int hold_of(input logic [IW-1:0] w);
    logic [1:0] c;
    c = w[IW-1 -: 2];
    if (c == 2'b10) return 4;   // LOAD_R
    if (c == 2'b11) return 3;   // STORE_R
    return 3;                   // ALU
  endfunction

  task automatic push(input logic [IW-1:0] w, input int addr, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({PB'(addr), w});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: one pop per valid cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [EW-1:0] e;
      checks++;
      if (busy !== instr_valid) begin
        errors++;
        $display("FAIL busy_vs_valid actual busy=%0b required=%0b", busy, instr_valid);
      end
      if (done === 1'b1) done_cnt++;
      if (instr_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue actual pc=%0d instr=%05h required none",
                   pc, instruction);
        end else begin
          e = exp_q.pop_front();
          if ({pc, instruction} !== e) begin
            errors++;
            $display("FAIL issue actual pc=%0d instr=%05h required pc=%0d instr=%05h",
                     pc, instruction, e[EW-1 -: PB], e[IW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [PB-1:0] a, input logic [IW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout actual busy=1 required 0 within 200 cycles");
    end
    @(negedge clk);
  endtask

  task automatic pulse_and_wait(input bit is_start, output int cyc);
    @(negedge clk);
    if (is_start) start = 1'b1; else step = 1'b1;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic push_full_run();
    for (int i = 0; i < 7; i++) push(words[i], i, hold_of(words[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_instruction", 32'(instruction), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;

    // Full 7-word run.
    for (int i = 0; i < 7; i++) write_word(PB'(i), words[i]);
    last_pc = 5'd6;
    push_full_run();
    pulse_and_wait(1'b1, cyc);
    check("run_busy_cycles", 32'(cyc), 23);
    check("run_done_count", 32'(done_cnt), 1);
    check("run_end_pc", 32'(pc), 0);
    check("run_end_valid", 32'(instr_valid), 0);
    check("run_queue_empty", 32'(exp_q.size()), 0);
`ifdef CPU_SEQ_RETIRE_COUNT_EN
    check("run_retired", 32'(retired), 7);
`endif

    // Single steps with wrap at last_pc.
    last_pc = 5'd2;
    for (int i = 0; i < 3; i++) begin
      push(words[i], i, 3);
      pulse_and_wait(1'b0, cyc);
      check("step_busy_cycles", 32'(cyc), 3);
      check("step_pc", 32'(pc), (i + 1) % 3);
    end
    check("step_no_done", 32'(done_cnt), 1);

    // Halt during the second hold cycle of pc=1.
    last_pc = 5'd6;
    push(words[0], 0, 3);
    push(words[1], 1, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    wait_idle(cyc);
    check("halt_pc", 32'(pc), 2);
    check("halt_valid", 32'(instr_valid), 0);
    check("halt_state", 32'(state), 32'(IDLE));
    check("halt_no_done", 32'(done_cnt), 1);
    check("halt_queue_empty", 32'(exp_q.size()), 0);

    // prog_we and start together: write lands, start dropped.
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 20'h12345; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    check("we_start_busy", 32'(busy), 0);
    @(negedge clk);
    check("we_start_busy_later", 32'(busy), 0);
    push(20'h12345, 2, 3);
    pulse_and_wait(1'b0, cyc);
    check("we_step_cycles", 32'(cyc), 3);
    check("we_step_pc", 32'(pc), 3);
    write_word(5'd2, words[2]);

    // prog_we during RUN is ignored.
    last_pc = 5'd1;
    push(words[0], 0, 3);
    push(words[1], 1, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'hFFFFF;
    @(negedge clk); prog_we = 1'b0;
    wait_idle(cyc);
    check("short_run_done", 32'(done_cnt), 2);
    check("short_run_pc", 32'(pc), 0);
    push(words[0], 0, 3);
    pulse_and_wait(1'b0, cyc);
    check("mem_kept_cycles", 32'(cyc), 3);

    // Reset during the LOAD hold of pc=5.
    last_pc = 5'd6;
    for (int i = 0; i < 5; i++) push(words[i], i, 3);
    push(words[5], 5, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_instruction", 32'(instruction), 0);
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_pc", 32'(pc), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_state", 32'(state), 32'(IDLE));
    check("arst_queue_empty", 32'(exp_q.size()), 0);
    @(negedge clk); rst_n = 1'b1;
    push_full_run();
    pulse_and_wait(1'b1, cyc);
    check("replay_cycles", 32'(cyc), 23);
    check("replay_done", 32'(done_cnt), 3);
    check("replay_queue_empty", 32'(exp_q.size()), 0);
`ifdef CPU_SEQ_RETIRE_COUNT_EN
    check("replay_retired", 32'(retired), 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/cpu_instr_sequencer.md
# cpu_instr_sequencer

Instruction sequencer for `simple_cpu`. It holds a small program memory of 20-bit instructions and issues them one at a time on the CPU's `instruction` input. Each instruction is held stable for exactly the number of clock cycles its class needs to complete. It replaces hand-timed instruction driving, and provides run, single-step and halt control.

## Interface

Parameters:
- `INSTR_WIDTH`, 20: instruction width; must match `simple_cpu`.
- `PC_BITS`, 5: program memory address width (32 entries).
- `ALU_CYCLES`, 3: hold cycles for ALU class (ADD/SUB); legal range 1..15.
- `STORE_CYCLES`, 3: hold cycles for STORE_R; legal range 1..15.
- `LOAD_CYCLES`, 4: hold cycles for LOAD_R; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `prog_we` in 1: program memory write strobe; honoured only in IDLE.
- `prog_addr` in PC_BITS: write address.
- `prog_data` in INSTR_WIDTH: write data.
- `last_pc` in PC_BITS: address of the final program instruction.
- `start` in 1: pulse; run from address 0 through `last_pc`.
- `step` in 1: pulse; execute one instruction at `pc`.
- `halt_req` in 1: finish the current instruction, then stop.
- `instruction` out INSTR_WIDTH: registered instruction to `simple_cpu`.
- `instr_valid` out 1: high while `instruction` carries a program word.
- `pc` out PC_BITS: address of the issued instruction, or of the next one when IDLE.
- `busy` out 1: high in RUN or STEP.
- `done` out 1: one-cycle pulse when a run reaches the end of `last_pc`.

## Operation

- Class decode uses `instruction[19:18]`:
  - 10 = LOAD_R
  - 11 = STORE_R
  - 00 or 01 = ALU
- Hold count N is the class parameter for the decoded class.
- Program memory:
  - Register array, asynchronous read.
  - Contents are not cleared by reset.
  - `prog_we` is ignored while `busy`.
- States:
  - IDLE: outputs `instruction`=0, `instr_valid`=0.
    - `start` → RUN, pc←0, issue mem[0].
    - `step` → STEP, issue mem[pc].
  - RUN: hold counter counts N−1 down to 0. At 0:
    - If pc==`last_pc`: → IDLE, pulse `done`, pc←0.
    - Else if `halt_req` is seen during this instruction: → IDLE, pc←pc+1.
    - Else: pc←pc+1 and issue mem[pc+1] on the same edge, with no gap cycle.
  - STEP: at counter 0 → IDLE.
    - pc←pc+1, or pc←0 if pc==`last_pc`.
    - `done` is not pulsed.
- `halt_req` is sticky within the current instruction and is cleared on entry to IDLE. It is ignored in IDLE.
- Priority in IDLE: `prog_we` > `start` > `step`.
  - A `start` or `step` in the same cycle as `prog_we` is dropped.
  - `start` and `step` in the same cycle means `start` wins.
- `start`/`step` are ignored while `busy`.
- pc increments wrap modulo 2^PC_BITS.
- If `last_pc` changes mid-run, the new value is used at the next end-of-instruction comparison.

## Timing

- Reset values: `instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Latency: `start` sampled at edge k gives `instruction`=mem[0] and `instr_valid`=1 after edge k.
- Each instruction is stable for exactly N rising edges. The next word appears on the edge that ends the hold.
- `done` is high for the single cycle after the final hold edge; `busy` falls on that same edge.
- A reset assertion mid-instruction immediately forces reset values. The CPU sees `instruction`=0 asynchronously.

## Configuration

- `CPU_SEQ_RETIRE_COUNT_EN`
  - Defined: adds output `retired` (16 bits). It is reset to 0 and increments by 1 on every hold completion in RUN or STEP. It wraps at 65535→0 and clears on `start`.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure

- Shared package `cpu_seq_pkg`:
  - Class encodings `CLS_LOAD`=2'b10 and `CLS_STORE`=2'b11.
  - State enum IDLE/RUN/STEP.
  - Default cycle constants.
- Sub-module `seq_prog_mem`: 2^PC_BITS × INSTR_WIDTH array with synchronous write and asynchronous read.
- Counter width is fixed at 4 bits.

## Test plan

- Program the 7-word sequence 0x47000, 0x53000, 0x72001, 0xD80F0, 0xCC160, 0xB80F0, 0x8C160; set `last_pc`=6; pulse `start`.
  - Each word holds 3, 3, 3, 3, 3, 4, 4 cycles respectively, with no gaps.
  - `done` pulses once; CPU ends with reg1=7.
- With `last_pc`=2, pulse `step` three times.
  - pc goes 0→1→2→0.
  - `busy` is high for 3 cycles per step.
  - `done` never asserts.
- Assert `halt_req` during the second hold cycle of pc=1 in a run.
  - pc=1 completes its full 3 cycles, then state is IDLE with pc=2 and `instr_valid`=0.
- Pulse `prog_we` and `start` together in IDLE.
  - The write lands and the start is dropped (`busy` stays 0).
  - `prog_we` during RUN leaves memory unchanged.
- Drive `rst_n` low mid-LOAD hold.
  - All outputs go to reset values immediately.
  - After release, `start` replays from pc=0.
- With `CPU_SEQ_RETIRE_COUNT_EN` defined, the 7-word run leaves `retired`=7.
